// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - producer request and UART transmitter handshake bundle
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   Req_Valid;
  logic [8*NUM_REQ-1:0] Req_Data;
  logic [NUM_REQ-1:0]   Req_Ready;
  logic                 Tx_newTransmissionData;
  logic [7:0]           Tx_TransmissionByte;
  logic                 Tx_active;
  logic                 Tx_done;

  modport master (
    input  Req_Valid,
    input  Req_Data,
    input  Tx_active,
    input  Tx_done,
    output Req_Ready,
    output Tx_newTransmissionData,
    output Tx_TransmissionByte
  );

  modport slave (
    output Req_Valid,
    output Req_Data,
    output Tx_active,
    output Tx_done,
    input  Req_Ready,
    input  Tx_newTransmissionData,
    input  Tx_TransmissionByte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter in front of a shared UART transmitter
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 87,
  parameter int GAP_CLKS     = 174,
  parameter int TIMEOUT_CLKS = 1000,
  localparam int ID_W        = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  uart_tx_arbiter_if.master tx_bus,
  output logic [ID_W-1:0]   Grant_Id,
  output logic              Busy,
  output logic              Timeout_Err
);

  localparam int WD_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam int GAP_W = (GAP_CLKS < 1) ? 1 : $clog2(GAP_CLKS + 1);

  // A watchdog shorter than one full frame would abort healthy bytes.
  if (TIMEOUT_CLKS <= 10 * CLKS_PER_BIT + 2) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must exceed one UART frame");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0] r_ready;
  logic               r_strobe;
  logic [7:0]         r_byte;
  logic [ID_W-1:0]    r_grant_id;
  logic               r_busy;
  logic               r_timeout;
  logic [WD_W-1:0]    r_wd_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;

  logic               w_found;
  logic [ID_W-1:0]    w_sel;
  logic [ID_W-1:0]    w_ptr_next;
  logic [NUM_REQ-1:0] w_sel_onehot;
  logic [7:0]         w_sel_byte;

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && tx_bus.Req_Valid[idx]) begin
        w_found = 1'b1;
        w_sel   = ID_W'(idx);
      end
    end
  end

  assign w_ptr_next   = (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + ID_W'(1);
  assign w_sel_onehot = NUM_REQ'(1) << w_sel;
  assign w_sel_byte   = tx_bus.Req_Data[8*w_sel +: 8];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_ready    <= '0;
      r_strobe   <= 1'b0;
      r_byte     <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_wd_cnt   <= '0;
      r_gap_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found && !tx_bus.Tx_active) begin
            r_ready    <= w_sel_onehot;
            r_strobe   <= 1'b1;
            r_byte     <= w_sel_byte;
            r_grant_id <= w_sel;
            r_ptr      <= w_ptr_next;
            r_busy     <= 1'b1;
            r_state    <= S_LAUNCH;
          end
        end

        // Tx_done here is ignored: the transmitter cannot finish this early.
        S_LAUNCH: begin
          r_ready  <= '0;
          r_strobe <= 1'b0;
          r_wd_cnt <= WD_W'(TIMEOUT_CLKS);
          r_state  <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (tx_bus.Tx_done) begin
            r_gap_cnt <= GAP_W'(GAP_CLKS);
            r_state   <= S_GAP;
          end else if (r_wd_cnt == '0) begin
            r_timeout <= 1'b1;
            r_gap_cnt <= GAP_W'(GAP_CLKS);
            r_state   <= S_GAP;
          end else begin
            r_wd_cnt <= r_wd_cnt - WD_W'(1);
          end
        end

        // Leave once the count runs out, but never while a hung transmitter is still active.
        S_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
          if ((r_gap_cnt <= GAP_W'(1)) && !tx_bus.Tx_active) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_bus.Req_Ready              = r_ready;
  assign tx_bus.Tx_newTransmissionData = r_strobe;
  assign tx_bus.Tx_TransmissionByte    = r_byte;
  assign Grant_Id                      = r_grant_id;
  assign Busy                          = r_busy;
  assign Timeout_Err                   = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int GAP = 174;
  localparam int TO  = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus();
  logic [1:0] gid;
  logic       busy;
  logic       terr;

  uart_tx_arbiter #(
    .NUM_REQ(N), .CLKS_PER_BIT(87), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO)
  ) dut (
    .Clock(clk), .Reset_n(rst_n), .tx_bus(bus),
    .Grant_Id(gid), .Busy(busy), .Timeout_Err(terr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter model: busy from the cycle after the strobe, done tx_len cycles after it.
  bit   hold_act = 1'b0;
  bit   tx_auto = 1'b1;
  int   tx_len = 871;
  logic m_act = 1'b0;
  logic m_done = 1'b0;
  assign bus.Tx_active = m_act | hold_act;
  assign bus.Tx_done   = m_done;

  always begin
    @(negedge clk);
    if (tx_auto && bus.Tx_newTransmissionData) begin
      @(posedge clk); #1 m_act = 1'b1;
      if (tx_len > 0) begin
        repeat (tx_len - 1) @(posedge clk);
        #1 m_done = 1'b1;
        @(posedge clk); #1 m_done = 1'b0; m_act = 1'b0;
      end else begin
        repeat (1200) @(posedge clk);
        #1 m_act = 1'b0;
      end
    end
  end

  // Reference model: timestamps of launch / end-of-wait, and the gap rule in cycle arithmetic.
  logic [3:0] e_ready;
  logic       e_strobe;
  logic [7:0] e_byte;
  logic [1:0] e_gid;
  logic       e_busy, e_to;
  int  m_ptr, t_launch, t_end, m_sel;
  bit  m_fly, m_found;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ready = '0; e_strobe = 1'b0; e_byte = '0; e_gid = '0;
      e_busy = 1'b0; e_to = 1'b0;
      m_ptr = 0; m_fly = 1'b0; t_launch = 0; t_end = -1;
    end else begin
      e_ready  = '0;
      e_strobe = 1'b0;
      if (m_fly) begin
        if (t_end < 0) begin
          if (cyc > t_launch && bus.Tx_done) t_end = cyc;
          else if (cyc == t_launch + TO + 1) begin
            t_end = cyc;
            e_to  = 1'b1;
          end
        end else if (cyc >= t_end + GAP && !bus.Tx_active) begin
          m_fly = 1'b0;
        end
      end else if (bus.Req_Valid != 0 && !bus.Tx_active) begin
        m_found = 1'b0;
        m_sel = 0;
        for (int k = 0; k < N; k++) begin
          if (!m_found && bus.Req_Valid[(m_ptr + k) % N]) begin
            m_found = 1'b1;
            m_sel = (m_ptr + k) % N;
          end
        end
        e_ready  = 4'(1 << m_sel);
        e_strobe = 1'b1;
        e_byte   = bus.Req_Data[8*m_sel +: 8];
        e_gid    = 2'(m_sel);
        m_ptr    = (m_sel + 1) % N;
        t_launch = cyc + 1;
        t_end    = -1;
        m_fly    = 1'b1;
      end
      e_busy = m_fly;
    end
  end

  always @(negedge clk) begin
    check("outputs {ready,strobe,byte,gid,busy,terr}",
          {bus.Req_Ready, bus.Tx_newTransmissionData, bus.Tx_TransmissionByte, gid, busy, terr},
          {e_ready, e_strobe, e_byte, e_gid, e_busy, e_to});
  end

  int last_done = 0;
  int n_strobe = 0;
  int rdy0_cnt = 0;
  always @(negedge clk) begin
    if (bus.Tx_done) last_done = cyc;
    if (bus.Tx_newTransmissionData) n_strobe++;
    if (bus.Req_Ready[0]) rdy0_cnt++;
  end

  int         ls;
  logic [7:0] s_byte;
  logic [3:0] s_ready;
  logic [1:0] s_gid;

  task automatic wait_strobe(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      if (bus.Tx_newTransmissionData) begin
        seen = 1'b1;
        ls = cyc;
        s_byte = bus.Tx_TransmissionByte;
        s_ready = bus.Req_Ready;
        s_gid = gid;
      end
    end
    if (!seen) check({name, "_strobe_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      if (!busy && !bus.Tx_active) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  logic [7:0] exp_b [5];
  logic [1:0] exp_g [5];
  int l1, f4, n0, bfall;
  bit fell;

  initial begin
    bus.Req_Valid = '0;
    bus.Req_Data  = '0;
    exp_b = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.Req_Ready, 0);
    check("rst_strobe", bus.Tx_newTransmissionData, 0);
    check("rst_byte", bus.Tx_TransmissionByte, 0);
    check("rst_gid", gid, 0);
    check("rst_terr", terr, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Single requester
    bus.Req_Data[7:0] = 8'hA5;
    bus.Req_Valid = 4'b0001;
    wait_strobe("t1a");
    l1 = ls;
    check("t1_byte", s_byte, 8'hA5);
    check("t1_ready", s_ready, 4'b0001);
    @(posedge clk); #2 bus.Req_Data[7:0] = 8'h5A;
    wait_strobe("t1b");
    check("t1_done_latency", last_done - l1, 871);
    check("t1_gap_respected", (ls - last_done) >= GAP + 1, 1);
    check("t1_byte2", s_byte, 8'h5A);
    @(posedge clk); #2 bus.Req_Valid = '0;
    check("t1_ready0_pulses", rdy0_cnt, 2);
    wait_idle();

    // Fairness from a fresh pointer
    do_reset();
    bus.Req_Data = 32'h40302010;
    bus.Req_Valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_strobe("t2");
      check("t2_byte", s_byte, exp_b[k]);
      check("t2_gid", s_gid, exp_g[k]);
    end
    @(posedge clk); #2 bus.Req_Valid = '0;
    wait_idle();

    // Pointer skip: move ptr to 2, then requesters 1 and 3
    bus.Req_Valid = 4'b0010;
    wait_strobe("t3a");
    check("t3_gid_first", s_gid, 1);
    @(posedge clk); #2 bus.Req_Valid = 4'b1010;
    wait_strobe("t3b");
    check("t3_gid_3", s_gid, 3);
    wait_strobe("t3c");
    check("t3_gid_1", s_gid, 1);
    @(posedge clk); #2 bus.Req_Valid = 4'b1111;
    wait_strobe("t3d");
    check("t3_ptr_ends_2", s_gid, 2);
    @(posedge clk); #2 bus.Req_Valid = '0;
    wait_idle();

    // Transmitter busy across reset release
    @(posedge clk); #2 rst_n = 1'b0; hold_act = 1'b1;
    bus.Req_Data[23:16] = 8'hC3;
    bus.Req_Valid = 4'b0100;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    n0 = n_strobe;
    repeat (500) @(posedge clk);
    check("t4_no_strobe_while_active", n_strobe - n0, 0);
    #2 hold_act = 1'b0;
    f4 = cyc;
    wait_strobe("t4");
    check("t4_strobe_latency", ls - f4, 1);
    check("t4_byte", s_byte, 8'hC3);
    @(posedge clk); #2 bus.Req_Valid = '0;
    wait_idle();

    // Watchdog
    tx_len = 0;
    bus.Req_Data[7:0] = 8'h77;
    bus.Req_Valid = 4'b0001;
    wait_strobe("t5");
    l1 = ls;
    @(posedge clk); #2 bus.Req_Valid = '0;
    while (cyc < l1 + 1000) @(negedge clk);
    check("t5_terr_before", terr, 0);
    while (cyc < l1 + 1002) @(negedge clk);
    check("t5_terr_set", terr, 1);
    fell = 1'b0;
    bfall = 0;
    for (int n = 0; n < 1000 && !fell; n++) begin
      @(negedge clk);
      if (!busy) begin
        fell = 1'b1;
        bfall = cyc;
      end
    end
    check("t5_idle_cycle", bfall - l1, 1202);
    check("t5_terr_sticky", terr, 1);
    tx_len = 871;

    // Reset in WAIT_DONE
    bus.Req_Data = 32'h44332211;
    bus.Req_Valid = 4'b1111;
    wait_strobe("t6a");
    check("t6_gid_before", s_gid, 1);
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_terr", terr, 0);
    check("t6_rst_ready", bus.Req_Ready, 0);
    check("t6_rst_strobe", bus.Tx_newTransmissionData, 0);
    check("t6_rst_gid", gid, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    wait_strobe("t6b");
    check("t6_ptr_zero", s_gid, 0);
    check("t6_byte", s_byte, 8'h11);
    @(posedge clk); #2 bus.Req_Valid = '0;
    wait_idle();

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
